// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Conditions raw pushbutton levels before they reach the controller. Each
// button goes through its own path:
//   1. A two flip-flop synchronizer into the i_clock domain.
//   2. A debounce counter. A change on the synchronized input is accepted
//      only after it has held for DEBOUNCE_CYCLES consecutive cycles.
//   3. A rising-edge detector. It emits a single-cycle pulse each time the
//      debounced level goes 0->1.
// The buttons share no state, so several of them may pulse in the same cycle.
//
// Parameters:
//   N_PULSADORES    number of independent buttons
//   DEBOUNCE_CYCLES cycles a change must persist before it is accepted (>= 1)
//   NB_COUNTER      counter width, 2^NB_COUNTER > DEBOUNCE_CYCLES-1
//
// Ports:
//   i_clock      system clock, rising edge
//   i_reset      asynchronous active-high reset, clears every register
//   i_pulsadores raw asynchronous button levels, 1 = pressed
//   o_pulsadores registered one-cycle press pulses
//   o_nivel      registered debounced button levels
// ---------------------------------------------------------------------------
module button_conditioner #(
    parameter int N_PULSADORES    = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NB_COUNTER      = 20
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [N_PULSADORES-1:0] i_pulsadores,
    output logic [N_PULSADORES-1:0] o_pulsadores,
    output logic [N_PULSADORES-1:0] o_nivel
);

    // Last count value before a change is accepted. The counter never goes
    // past this value, so it cannot wrap.
    localparam logic [NB_COUNTER-1:0] COUNT_LAST = NB_COUNTER'(DEBOUNCE_CYCLES - 1);

    // Per-button debounce state. It is decoded from whether the synchronized
    // input agrees with the accepted level, so it needs no storage of its own.
    typedef enum logic {
        IDLE     = 1'b0,
        COUNTING = 1'b1
    } deb_state_t;

    logic [N_PULSADORES-1:0] sync1;
    logic [N_PULSADORES-1:0] sync2;
    logic [N_PULSADORES-1:0] stable;
    logic [N_PULSADORES-1:0] stable_next;
    logic [NB_COUNTER-1:0]   counter      [N_PULSADORES];
    logic [NB_COUNTER-1:0]   counter_next [N_PULSADORES];
    deb_state_t              state        [N_PULSADORES];

    // Two-stage synchronizer. Only sync2 is used downstream. sync1 may go
    // metastable and is given a full cycle to settle.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= i_pulsadores;
            sync2 <= sync1;
        end
    end

    // Debounce next-state logic, evaluated independently for every button.
    // The counter runs only while the synchronized input differs from the
    // accepted level. A single agreeing cycle (a bounce) throws the count
    // away. Reaching COUNT_LAST while still differing accepts the new level
    // and restarts the counter from zero.
    always_comb begin
        for (int k = 0; k < N_PULSADORES; k++) begin
            state[k]        = (sync2[k] != stable[k]) ? COUNTING : IDLE;
            stable_next[k]  = stable[k];
            counter_next[k] = '0;
            case (state[k])
                IDLE: begin
                    counter_next[k] = '0;
                end
                COUNTING: begin
                    if (counter[k] == COUNT_LAST) begin
                        stable_next[k]  = sync2[k];
                        counter_next[k] = '0;
                    end else begin
                        counter_next[k] = counter[k] + 1'b1;
                    end
                end
                default: begin
                    counter_next[k] = '0;
                end
            endcase
        end
    end

    // State and output registers.
    // o_nivel and o_pulsadores are loaded from the same next-state values as
    // stable. This makes the press pulse appear on the very edge where the
    // accepted level rises. A falling level gives no pulse.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            stable       <= '0;
            o_nivel      <= '0;
            o_pulsadores <= '0;
            for (int k = 0; k < N_PULSADORES; k++) begin
                counter[k] <= '0;
            end
        end else begin
            stable       <= stable_next;
            o_nivel      <= stable_next;
            o_pulsadores <= stable_next & ~stable;
            for (int k = 0; k < N_PULSADORES; k++) begin
                counter[k] <= counter_next[k];
            end
        end
    end

endmodule
